mem_load_stage: RTL
===================

// Module: mem_load_stage
// PURPOSE
//  Parametrised MEM pipeline stage between M1 and WB. It holds one instruction and waits for
//  the DCache read response by handshake (dc_rvalid), not by a busy level. Load data is
//  aligned and extended in this stage (LB/LBU/LH/LHU/LW/LWL/LWR). A response that arrives
//  while WB stalls is captured, and a pending load is dropped cleanly on pipeline flush.
//  Forwards the destination, data and data-ready status to the ID bypass network.
// PARAMETERS
//  DEST_W    5   register-file address width
//  META_W    64  opaque sideband from M1 (exception codes, CP0 info) passed to WB unchanged
//  BYPASS_RESP 1 1: response goes combinationally to WB in its arrival cycle; 0: always registered first
// PORTS
//  clk            in   1       clock
//  resetn         in   1       asynchronous active-low reset
//  flush          in   1       exception/eret flush; kills the held instruction
//  m1s_valid      in   1       M1 presents an instruction
//  ms_allowin     out  1       stage accepts M1 instruction this cycle
//  m1s_pc         in   32      instruction PC
//  m1s_result     in   32      ALU result / effective address
//  m1s_rt_value   in   32      rt value (LWL/LWR merge)
//  m1s_load       in   1       instruction is a load with a DCache request in flight
//  m1s_load_type  in   3       0 LW,1 LB,2 LBU,3 LH,4 LHU,5 LWL,6 LWR (7 = LW)
//  m1s_gr_we      in   1       writes RF
//  m1s_dest       in   DEST_W  RF write address
//  m1s_ex         in   1       instruction carries an exception
//  m1s_meta       in   META_W  sideband
//  dc_rvalid      in   1       DCache read data valid (one pulse per load request)
//  dc_rdata       in   32      DCache read data
//  ws_allowin     in   1       WB accepts
//  ms_to_ws_valid out  1       WB payload valid
//  ms_pc, ms_wdata out 32 each PC; final RF write data
//  ms_gr_we, ms_ex out 1 each  forwarded flags
//  ms_dest        out  DEST_W  RF write address
//  ms_meta        out  META_W  sideband
//  fwd_dest       out  DEST_W  bypass address; 0 when no valid RF-writing instruction
//  fwd_data       out  32      bypass data (= ms_wdata)
//  fwd_ready      out  1       fwd_data is final; 0 means ID must stall (load-use)
// BEHAVIOUR
//  - Reset: state=EMPTY and all payload registers 0. All outputs 0, except ms_allowin=1.
//  - States: EMPTY, WAIT (load awaiting dc_rvalid), READY (result held), DROP (discard response).
//  - Accept: ms_allowin = EMPTY | (out_fire & ~flush); out_fire = ms_to_ws_valid & ws_allowin.
//    On m1s_valid & ms_allowin & ~flush, load the payload registers.
//    The next state is WAIT if m1s_load & ~m1s_ex, else READY.
//  - ms_to_ws_valid = READY | (WAIT & dc_rvalid & BYPASS_RESP).
//    In WAIT with dc_rvalid but no out_fire, the aligned data is captured -> READY.
//  - Fire without a new accept -> EMPTY. Back-to-back accept/fire gives 1 instruction/cycle for non-loads.
//  - Loads: LW = rdata. LB/LBU = byte at addr[1:0], sign/zero extended.
//    LH/LHU = half at addr[1], sign/zero extended (alignment already checked upstream).
//    LWL a=0..3: {rd[7:0],rt[23:0]}, {rd[15:0],rt[15:0]}, {rd[23:0],rt[7:0]}, rd.
//    LWR a=0..3: rd, {rt[31:24],rd[31:8]}, {rt[31:16],rd[31:16]}, {rt[31:8],rd[31:24]}.
//    Non-load: ms_wdata = m1s_result.
//  - Flush:
//    EMPTY/READY -> EMPTY next cycle; ms_to_ws_valid is masked in the flush cycle.
//    WAIT & ~dc_rvalid -> DROP. WAIT & dc_rvalid -> EMPTY (response consumed).
//    DROP: ms_allowin=0 until dc_rvalid, then -> EMPTY. A flush in DROP stays DROP.
//  - A dc_rvalid in EMPTY or READY is a protocol error: ignored, flagged by a simulation assertion.
//  - fwd_dest = ms_dest when state in {WAIT,READY} & ms_gr_we, else 0.
//    fwd_ready = READY | (WAIT & dc_rvalid).
//  - Reset mid-load: returns to EMPTY immediately; the DCache is reset by the same resetn.
// STRUCTURE
//  - Load type codes and state encodings are `define constants in global_defines.vh (LDT_*, MS_ST_*).
//  - Sub-module load_align (combinational): type, addr[1:0], rdata, rt -> aligned word.
//    It is reused by a future dual-issue MEM stage.
//  - Top level: FSM + payload register + response capture register.
// TESTING
//  1 ALU op result=0x1234 dest=3, ws_allowin=1 -> ms_to_ws_valid next cycle, ms_wdata=0x1234,
//    fwd_ready=1; 4 back-to-back ops retire 1/cycle.
//  2 LB addr=...1, rdata=0x0000_8000, dc_rvalid 3 cycles later -> wdata=0xFFFF_FF80.
//    fwd_dest=dest, fwd_ready=0 during wait.
//  3 LWL addr=...2, rt=0xAABBCCDD, rdata=0x11223344 -> 0x223344DD.
//    LWR addr=...1, same operands -> 0xAA112233.
//  4 Load response while ws_allowin=0 for 5 cycles -> data held; ms_allowin=0; one fire when ws_allowin=1.
//  5 Flush in WAIT, dc_rvalid 2 cycles later -> no ms_to_ws_valid, ms_allowin=0 until rvalid,
//    next load's data is correct.
//  6 resetn asserted during WAIT -> outputs 0 immediately; after release the first instruction passes.

Source files
------------

// File: rtl/mem_load_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_load_stage_pkg
//   Shared definitions for the MEM load stage: the stage FSM encoding and the
//   load type codes carried from M1. Imported by mem_load_stage and by the
//   load alignment sub-module.
// -----------------------------------------------------------------------------
package mem_load_stage_pkg;

    // EMPTY: nothing held, WAIT: load waiting for dc_rvalid,
    // READY: final result held, DROP: flushed load whose response is discarded
    typedef enum logic [1:0] {
        MS_ST_EMPTY = 2'd0,
        MS_ST_WAIT  = 2'd1,
        MS_ST_READY = 2'd2,
        MS_ST_DROP  = 2'd3
    } ms_state_e;

    // Load type codes; code 7 is treated as LW
    localparam logic [2:0] LDT_LW  = 3'd0;
    localparam logic [2:0] LDT_LB  = 3'd1;
    localparam logic [2:0] LDT_LBU = 3'd2;
    localparam logic [2:0] LDT_LH  = 3'd3;
    localparam logic [2:0] LDT_LHU = 3'd4;
    localparam logic [2:0] LDT_LWL = 3'd5;
    localparam logic [2:0] LDT_LWR = 3'd6;

endpackage

// File: rtl/mem_load_stage_align.sv
// -----------------------------------------------------------------------------
// mem_load_stage_align
//   Combinational load data alignment / extension (little-endian).
//   Ports:
//     i_load_type  load type code (LDT_*)
//     i_addr       low two bits of the effective address
//     i_rdata      raw 32-bit word returned by the DCache
//     i_rt         old rt value, merged in by LWL/LWR
//     o_word       final register-file write data
//   Kept separate so a second MEM lane can reuse it.
// -----------------------------------------------------------------------------
module mem_load_stage_align
    import mem_load_stage_pkg::*;
(
    input  logic [2:0]  i_load_type,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_rt,
    output logic [31:0] o_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword out of the returned word
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extend or merge according to the load type; LWL/LWR keep the rt bytes
    // that the unaligned access does not touch
    always_comb begin
        o_word = i_rdata;
        case (i_load_type)
            LDT_LB:  o_word = {{24{w_byte[7]}}, w_byte};
            LDT_LBU: o_word = {24'h0, w_byte};
            LDT_LH:  o_word = {{16{w_half[15]}}, w_half};
            LDT_LHU: o_word = {16'h0, w_half};
            LDT_LWL: begin
                case (i_addr)
                    2'd0:    o_word = {i_rdata[7:0],  i_rt[23:0]};
                    2'd1:    o_word = {i_rdata[15:0], i_rt[15:0]};
                    2'd2:    o_word = {i_rdata[23:0], i_rt[7:0]};
                    default: o_word = i_rdata;
                endcase
            end
            LDT_LWR: begin
                case (i_addr)
                    2'd0:    o_word = i_rdata;
                    2'd1:    o_word = {i_rt[31:24], i_rdata[31:8]};
                    2'd2:    o_word = {i_rt[31:16], i_rdata[31:16]};
                    default: o_word = {i_rt[31:8],  i_rdata[31:24]};
                endcase
            end
            default: o_word = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_load_stage.sv
// -----------------------------------------------------------------------------
// mem_load_stage
//   MEM pipeline stage between M1 and WB. Holds one instruction, waits for the
//   DCache read response by handshake (dc_rvalid), aligns load data, and
//   forwards dest/data/ready to the ID bypass network.
//   Ports:
//     clk, resetn            clock, asynchronous active-low reset
//     flush                  kills the held instruction
//     m1s_*                  instruction payload from M1, ms_allowin back-pressure
//     dc_rvalid, dc_rdata    DCache read response (one pulse per load request)
//     ws_allowin             WB accepts
//     ms_to_ws_valid, ms_*   payload to WB
//     fwd_dest/data/ready    bypass information for ID
// -----------------------------------------------------------------------------
module mem_load_stage
    import mem_load_stage_pkg::*;
#(
    parameter int DEST_W      = 5,
    parameter int META_W      = 64,
    parameter bit BYPASS_RESP = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              m1s_valid,
    output logic              ms_allowin,
    input  logic [31:0]       m1s_pc,
    input  logic [31:0]       m1s_result,
    input  logic [31:0]       m1s_rt_value,
    input  logic              m1s_load,
    input  logic [2:0]        m1s_load_type,
    input  logic              m1s_gr_we,
    input  logic [DEST_W-1:0] m1s_dest,
    input  logic              m1s_ex,
    input  logic [META_W-1:0] m1s_meta,
    input  logic              dc_rvalid,
    input  logic [31:0]       dc_rdata,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [31:0]       ms_pc,
    output logic [31:0]       ms_wdata,
    output logic              ms_gr_we,
    output logic              ms_ex,
    output logic [DEST_W-1:0] ms_dest,
    output logic [META_W-1:0] ms_meta,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [31:0]       fwd_data,
    output logic              fwd_ready
);

    ms_state_e         r_state;
    ms_state_e         w_next_state;

    logic [31:0]       r_pc;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rt;
    logic [2:0]        r_load_type;
    logic              r_gr_we;
    logic [DEST_W-1:0] r_dest;
    logic              r_ex;
    logic [META_W-1:0] r_meta;

    logic              w_out_valid;
    logic              w_fire;
    logic              w_allowin;
    logic              w_accept;
    logic              w_capture;
    logic              w_fwd_live;
    logic              w_fwd_ready;
    logic              w_resp_now;
    logic [31:0]       w_aligned;

    // r_wdata holds the effective address while waiting, so its low bits
    // select the byte lanes until the response overwrites it
    mem_load_stage_align u_align (
        .i_load_type (r_load_type),
        .i_addr      (r_wdata[1:0]),
        .i_rdata     (dc_rdata),
        .i_rt        (r_rt),
        .o_word      (w_aligned)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= MS_ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output / handshake decode; flush masks any hand-off to WB in its cycle
    always_comb begin
        w_out_valid = 1'b0;
        w_fwd_live  = 1'b0;
        w_fwd_ready = 1'b0;
        case (r_state)
            MS_ST_WAIT: begin
                w_out_valid = dc_rvalid & BYPASS_RESP & ~flush;
                w_fwd_live  = 1'b1;
                w_fwd_ready = dc_rvalid;
            end
            MS_ST_READY: begin
                w_out_valid = ~flush;
                w_fwd_live  = 1'b1;
                w_fwd_ready = 1'b1;
            end
            default: begin
                w_out_valid = 1'b0;
            end
        endcase
        w_fire     = w_out_valid & ws_allowin;
        w_allowin  = (r_state == MS_ST_EMPTY) | (w_fire & ~flush);
        w_accept   = m1s_valid & w_allowin & ~flush;
        w_resp_now = (r_state == MS_ST_WAIT) & dc_rvalid;
        w_capture  = w_resp_now & ~w_fire & ~flush;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MS_ST_EMPTY: begin
                if (w_accept)
                    w_next_state = (m1s_load & ~m1s_ex) ? MS_ST_WAIT : MS_ST_READY;
            end
            MS_ST_WAIT: begin
                if (flush)
                    w_next_state = dc_rvalid ? MS_ST_EMPTY : MS_ST_DROP;
                else if (w_accept)
                    w_next_state = (m1s_load & ~m1s_ex) ? MS_ST_WAIT : MS_ST_READY;
                else if (w_fire)
                    w_next_state = MS_ST_EMPTY;
                else if (dc_rvalid)
                    w_next_state = MS_ST_READY;
            end
            MS_ST_READY: begin
                if (flush)
                    w_next_state = MS_ST_EMPTY;
                else if (w_accept)
                    w_next_state = (m1s_load & ~m1s_ex) ? MS_ST_WAIT : MS_ST_READY;
                else if (w_fire)
                    w_next_state = MS_ST_EMPTY;
            end
            MS_ST_DROP: begin
                if (dc_rvalid)
                    w_next_state = MS_ST_EMPTY;
            end
            default: w_next_state = MS_ST_EMPTY;
        endcase
    end

    // Payload register; a response that WB could not take is written over
    // the stored address so the held result is final
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc        <= '0;
            r_wdata     <= '0;
            r_rt        <= '0;
            r_load_type <= '0;
            r_gr_we     <= 1'b0;
            r_dest      <= '0;
            r_ex        <= 1'b0;
            r_meta      <= '0;
        end else if (w_accept) begin
            r_pc        <= m1s_pc;
            r_wdata     <= m1s_result;
            r_rt        <= m1s_rt_value;
            r_load_type <= m1s_load_type;
            r_gr_we     <= m1s_gr_we;
            r_dest      <= m1s_dest;
            r_ex        <= m1s_ex;
            r_meta      <= m1s_meta;
        end else if (w_capture) begin
            r_wdata     <= w_aligned;
        end
    end

    assign ms_allowin     = w_allowin;
    assign ms_to_ws_valid = w_out_valid;
    assign ms_pc          = r_pc;
    assign ms_wdata       = w_resp_now ? w_aligned : r_wdata;
    assign ms_gr_we       = r_gr_we;
    assign ms_ex          = r_ex;
    assign ms_dest        = r_dest;
    assign ms_meta        = r_meta;
    assign fwd_dest       = (w_fwd_live & r_gr_we) ? r_dest : '0;
    assign fwd_data       = ms_wdata;
    assign fwd_ready      = w_fwd_ready;

    // A response with no load outstanding means the DCache lost track
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!resetn)
        !(dc_rvalid && ((r_state == MS_ST_EMPTY) || (r_state == MS_ST_READY))));

endmodule
